// File: rtl/fifo_stream_reader_if.sv
// Framed valid/ready stream carrying words drained from a FIFO.
interface fifo_stream_reader_if #(parameter int DWIDTH = 32);
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              last_o;
  logic              ready_i;

  modport master (output data_o, valid_o, last_o, input ready_i);
  modport slave  (input data_o, valid_o, last_o, output ready_i);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a non-showahead FIFO (one-cycle registered read) into a framed
// valid/ready stream through a 3-entry skid buffer.
module fifo_stream_reader #(
  parameter int DWIDTH  = 32,
  parameter int PKT_LEN = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic [DWIDTH-1:0]    fifo_q_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rdreq_o,
  output logic                 idle_o,
  fifo_stream_reader_if.master st
);
  localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);

  logic [2:0][DWIDTH-1:0] mem_q;
  logic [1:0]             wr_ptr_q, rd_ptr_q, occ_q;
  logic                   inflight_q;
  logic [BW-1:0]          beat_q;
  logic                   pop, last;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue only if the new word plus the one already owed still fit; ready_i
  // is deliberately absent so the FIFO side never sees downstream timing.
  assign fifo_rdreq_o = rst_n_i && enable_i && !fifo_empty_i &&
                        (({1'b0, occ_q} + {2'b0, inflight_q}) <= 3'd2);

  assign st.valid_o = (occ_q != 2'd0);
  assign st.data_o  = mem_q[rd_ptr_q];
  assign last       = st.valid_o && (beat_q == BEAT_LAST);
  assign st.last_o  = last;
  assign pop        = st.valid_o && st.ready_i;
  assign idle_o     = (occ_q == 2'd0) && !inflight_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= fifo_rdreq_o;
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= fifo_q_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        beat_q   <= last ? '0 : beat_q + BW'(1);
      end
      case ({inflight_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench: FIFO model plus a queue scoreboard and an
// occupancy model shared by three readers (PKT_LEN 8, 1 and 5).
module tb_fifo_stream_reader;
  localparam int DW = 32;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ready = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q = '0, wdata = '0;
  logic          fifo_empty = 1'b1, wr = 1'b0;
  logic [DW-1:0] fq[$], exp_q[$];
  logic          rdreq8, rdreq1, rdreq5, idle8, idle1, idle5;

  fifo_stream_reader_if #(.DWIDTH(DW)) s8 ();
  fifo_stream_reader_if #(.DWIDTH(DW)) s1 ();
  fifo_stream_reader_if #(.DWIDTH(DW)) s5 ();
  assign s8.ready_i = ready;
  assign s1.ready_i = ready;
  assign s5.ready_i = ready;

  fifo_stream_reader #(.DWIDTH(DW), .PKT_LEN(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .fifo_q_i(fifo_q),
    .fifo_empty_i(fifo_empty), .fifo_rdreq_o(rdreq8), .idle_o(idle8), .st(s8));
  fifo_stream_reader #(.DWIDTH(DW), .PKT_LEN(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .fifo_q_i(fifo_q),
    .fifo_empty_i(fifo_empty), .fifo_rdreq_o(rdreq1), .idle_o(idle1), .st(s1));
  fifo_stream_reader #(.DWIDTH(DW), .PKT_LEN(5)) dut5 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .fifo_q_i(fifo_q),
    .fifo_empty_i(fifo_empty), .fifo_rdreq_o(rdreq5), .idle_o(idle5), .st(s5));

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model: registered read data and registered empty flag.
  always @(posedge clk) begin
    if (rdreq8 && fq.size() != 0) fifo_q <= fq.pop_front();
    if (wr) begin
      fq.push_back(wdata);
      exp_q.push_back(wdata);
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Occupancy model: words owed by the FIFO minus words taken downstream.
  int m_occ = 0;
  bit m_inf = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_occ = 0;
      m_inf = 1'b0;
    end else begin
      m_occ = m_occ + (m_inf ? 1 : 0) - ((m_occ != 0 && ready) ? 1 : 0);
      m_inf = rdreq8;
    end
  end

  int n_rd = 0, n_pop = 0, acc = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic prev_l = 1'b0, prev_l5 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (rdreq8) n_rd++;
      chk("rdreq8", rdreq8, enable && !fifo_empty && (m_occ + m_inf <= 2));
      chk("rdreq1", rdreq1, enable && !fifo_empty && (m_occ + m_inf <= 2));
      chk("rdreq5", rdreq5, enable && !fifo_empty && (m_occ + m_inf <= 2));
      chk("valid", {s8.valid_o, s1.valid_o, s5.valid_o}, {3{m_occ != 0}});
      chk("idle", {idle8, idle1, idle5}, {3{m_occ == 0 && !m_inf}});
      chk("occ_max", m_occ <= 3, 1'b1);
      if (m_inf) chk("cap_room", (m_occ < 3) || ready, 1'b1);
      if (m_occ == 0) chk("last_nv", {s8.last_o, s1.last_o, s5.last_o}, 3'b0);
      if (prev_stall) begin
        chk("stall_data", s8.data_o, prev_d);
        chk("stall_last", {s8.last_o, s5.last_o}, {prev_l, prev_l5});
      end
      if (m_occ != 0 && ready) begin
        if (exp_q.size() == 0) chk("spurious", 1'b1, 1'b0);
        else begin
          chk("data8", s8.data_o, exp_q[0]);
          chk("data1", s1.data_o, exp_q[0]);
          chk("data5", s5.data_o, exp_q[0]);
          chk("last8", s8.last_o, (acc % 8) == 7);
          chk("last1", s1.last_o, 1'b1);
          chk("last5", s5.last_o, (acc % 5) == 4);
          void'(exp_q.pop_front());
          acc++;
          n_pop++;
        end
      end
      prev_stall = (m_occ != 0) && !ready;
      prev_d     = s8.data_o;
      prev_l     = s8.last_o;
      prev_l5    = s5.last_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr    = 1'b1;
      wdata = base + DW'(i);
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(idle8 && fifo_empty) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_timeout", k < budget, 1'b1);
  endtask

  task automatic chk_rst_vals(input string w);
    chk({w, "_rdreq"}, {rdreq8, rdreq1, rdreq5}, 3'b0);
    chk({w, "_valid"}, {s8.valid_o, s1.valid_o, s5.valid_o}, 3'b0);
    chk({w, "_last"}, {s8.last_o, s1.last_o, s5.last_o}, 3'b0);
    chk({w, "_data"}, s8.data_o, 0);
    chk({w, "_idle"}, {idle8, idle1, idle5}, 3'b111);
  endtask

  // Counts negedges until valid_o, starting at the current cycle.
  task automatic lat_to_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!s8.valid_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, run, r0, p0;
    enable = 1'b1;
    #3;
    chk_rst_vals("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Full rate: 16 preloaded words stream back to back.
    enable = 1'b0; ready = 1'b1;
    push_words(32'h0, 16);
    tick();
    enable = 1'b1;
    lat_to_valid(lat);
    chk("fr_latency", lat, 2);
    run = 0;
    while (s8.valid_o && run < 40) begin
      run++;
      @(negedge clk);
    end
    chk("fr_run", run, 16);
    tick();

    // Backpressure: only three reads before the buffer is full.
    enable = 1'b0; ready = 1'b0;
    push_words(32'h100, 10);
    tick();
    r0 = n_rd; p0 = n_pop;
    enable = 1'b1;
    repeat (10) tick();
    chk("bp_reads", n_rd - r0, 3);
    chk("bp_head", s8.data_o, 32'h100);
    ready = 1'b1;
    wait_idle(60);
    chk("bp_count", n_pop - p0, 10);

    // Enable for one cycle: the in-flight word still arrives, nothing else.
    enable = 1'b0;
    push_words(32'h200, 12);
    tick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    r0 = n_rd; p0 = n_pop;
    repeat (8) tick();
    chk("en_reads", n_rd - r0, 0);
    chk("en_pops", n_pop - p0, 1);
    enable = 1'b1;
    wait_idle(60);

    // Asynchronous reset with two words buffered.
    enable = 1'b0; ready = 1'b0;
    push_words(32'h300, 2);
    tick();
    enable = 1'b1;
    repeat (5) tick();
    chk("pre_rst_valid", s8.valid_o, 1'b1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    acc = 0;
    #1 chk_rst_vals("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; ready = 1'b1;
    fork
      push_words(32'h400, 4);
      begin
        int k = 0;
        while (fifo_empty && k < 10) begin
          @(negedge clk);
          k++;
        end
        lat = 0;
        while (!s8.valid_o && lat < 10) begin
          @(negedge clk);
          lat++;
        end
        chk("rst_latency", lat, 2);
      end
    join
    wait_idle(40);

    // Random writes and random ready, 1000 words.
    p0 = n_pop;
    begin
      int sent = 0;
      while (sent < 1000) begin
        wr    = 1'($urandom_range(0, 1));
        wdata = $urandom;
        ready = 1'($urandom_range(0, 1));
        if (wr) sent++;
        tick();
      end
    end
    wr = 1'b0; ready = 1'b1;
    wait_idle(200);
    chk("rand_count", n_pop - p0, 1000);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
